// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter that shares the write port of a synchronous FIFO between
// NUM_REQ producers. It issues at most one registered write per cycle, throttles
// on full/almostfull, checks each issued write for an ack one cycle later, and
// keeps saturating stall/error statistics.
//
// Ports
//   clk_i              clock, all logic on posedge
//   rst_n_i            synchronous active-low reset
//   arb_en_i           1 = new grants allowed
//   req_i              per-requester request, held with data until granted
//   req_data_i         slice i = [i*FIFO_WIDTH +: FIFO_WIDTH]
//   gnt_o              registered one-hot grant (pulse = word issued this cycle)
//   fifo_wr_en_o       registered FIFO wr_en
//   fifo_data_in_o     registered FIFO data_in
//   fifo_full_i        FIFO full
//   fifo_almostfull_i  FIFO almostfull (count == DEPTH-1)
//   fifo_wr_ack_i      FIFO wr_ack, one cycle after wr_en
//   fifo_overflow_i    FIFO overflow
//   arb_state_o        00 IDLE, 01 GRANT, 10 BLOCKED
//   stall_cnt_o        saturating count of cycles spent in BLOCKED
//   err_cnt_o          saturating count of writes not acked or overflowed
//   ack_err_o          sticky flag, set on the first ack error
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          arb_en_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          fifo_wr_en_o,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_almostfull_i,
    input  logic                          fifo_wr_ack_i,
    input  logic                          fifo_overflow_i,
    output logic [1:0]                    arb_state_o,
    output logic [CNT_WIDTH-1:0]          stall_cnt_o,
    output logic [CNT_WIDTH-1:0]          err_cnt_o,
    output logic                          ack_err_o
);

    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_BLOCKED = 2'b10
    } arb_state_e;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    arb_state_e                state_q, state_d;
    logic [IDXW-1:0]           last_q, last_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d;
    logic                      wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0]     data_q, data_d;
    logic                      inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]      stall_q, stall_d;
    logic [CNT_WIDTH-1:0]      err_q, err_d;
    logic                      ack_err_q, ack_err_d;

    logic                      blocked;
    logic                      found;
    logic [IDXW:0]             sum;
    logic [IDXW-1:0]           win_idx;
    logic [NUM_REQ-1:0]        win_onehot;
    logic [FIFO_WIDTH-1:0]     win_data;

    // The last FIFO slot is reserved for the write already on the bus.
    assign blocked = fifo_full_i | (fifo_almostfull_i & wr_en_q);

    // Round-robin search: first set request at or after last+1, wrapping.
    always_comb begin
        found   = 1'b0;
        win_idx = last_q;
        sum     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_q} + (IDXW+1)'(k);
            if (sum >= (IDXW+1)'(NUM_REQ)) begin
                sum = sum - (IDXW+1)'(NUM_REQ);
            end
            if (!found && req_i[sum[IDXW-1:0]]) begin
                found   = 1'b1;
                win_idx = sum[IDXW-1:0];
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDXW'(i)) begin
                win_onehot[i] = 1'b1;
                win_data      = req_data_i[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // Decision stage: classify the edge, pick the grant, run the ack check.
    always_comb begin
        state_d    = ST_IDLE;
        gnt_d      = '0;
        wr_en_d    = 1'b0;
        data_d     = data_q;
        last_d     = last_q;
        stall_d    = stall_q;
        err_d      = err_q;
        ack_err_d  = ack_err_q;
        inflight_d = wr_en_q;

        // A write issued last cycle must be acked now, without overflow.
        if (inflight_q && (!fifo_wr_ack_i || fifo_overflow_i)) begin
            err_d     = sat_inc(err_q);
            ack_err_d = 1'b1;
        end

        if (arb_en_i && (|req_i)) begin
            if (blocked) begin
                state_d = ST_BLOCKED;
                stall_d = sat_inc(stall_q);
            end else begin
                state_d = ST_GRANT;
                gnt_d   = win_onehot;
                wr_en_d = 1'b1;
                data_d  = win_data;
                last_d  = win_idx;
            end
        end
    end

    // Output register stage.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            last_q     <= IDXW'(NUM_REQ-1);
            gnt_q      <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            inflight_q <= 1'b0;
            stall_q    <= '0;
            err_q      <= '0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign gnt_o          = gnt_q;
    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_data_in_o = data_q;
    assign arb_state_o    = state_q;
    assign stall_cnt_o    = stall_q;
    assign err_cnt_o      = err_q;
    assign ack_err_o      = ack_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter with a behavioural reference model and a
// per-cycle compare process, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int FW = 16;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arb_en = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*FW-1:0]  req_data;
    logic [NR-1:0]     gnt;
    logic              fifo_wr_en;
    logic [FW-1:0]     fifo_data_in;
    logic              fifo_full = 1'b0;
    logic              fifo_almostfull = 1'b0;
    logic              fifo_wr_ack = 1'b0;
    logic              fifo_overflow = 1'b0;
    logic [1:0]        arb_state;
    logic [CW-1:0]     stall_cnt;
    logic [CW-1:0]     err_cnt;
    logic              ack_err;

    logic [FW-1:0]     slot [NR];

    int n_chk = 0;
    int n_fail = 0;
    logic wen_prev = 1'b0;
    logic ack_kill = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NR; i++) req_data[i*FW +: FW] = slot[i];
    end

    fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .arb_en_i          (arb_en),
        .req_i             (req),
        .req_data_i        (req_data),
        .gnt_o             (gnt),
        .fifo_wr_en_o      (fifo_wr_en),
        .fifo_data_in_o    (fifo_data_in),
        .fifo_full_i       (fifo_full),
        .fifo_almostfull_i (fifo_almostfull),
        .fifo_wr_ack_i     (fifo_wr_ack),
        .fifo_overflow_i   (fifo_overflow),
        .arb_state_o       (arb_state),
        .stall_cnt_o       (stall_cnt),
        .err_cnt_o         (err_cnt),
        .ack_err_o         (ack_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each output must be after every edge.
    logic [NR-1:0] m_gnt = '0;
    logic          m_wen = 1'b0;
    logic [FW-1:0] m_data = '0;
    logic [1:0]    m_state = 2'b00;
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_err = '0;
    logic          m_ackerr = 1'b0;
    logic          m_inflight = 1'b0;
    int            m_last = NR-1;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_gnt = '0; m_wen = 1'b0; m_data = '0; m_state = 2'b00;
            m_stall = '0; m_err = '0; m_ackerr = 1'b0; m_inflight = 1'b0;
            m_last = NR-1;
        end else begin
            if (m_inflight && (!fifo_wr_ack || fifo_overflow)) begin
                if (m_err != {CW{1'b1}}) m_err = m_err + 1'b1;
                m_ackerr = 1'b1;
            end
            m_inflight = m_wen;
            if (!arb_en || req == '0) begin
                m_state = 2'b00; m_gnt = '0; m_wen = 1'b0;
            end else if (fifo_full || (fifo_almostfull && m_wen)) begin
                m_state = 2'b10; m_gnt = '0; m_wen = 1'b0;
                if (m_stall != {CW{1'b1}}) m_stall = m_stall + 1'b1;
            end else begin
                int w;
                w = -1;
                for (int k = 1; k <= NR; k++) begin
                    if (w < 0 && req[(m_last + k) % NR]) w = (m_last + k) % NR;
                end
                m_state = 2'b01;
                m_gnt   = NR'(1) << w;
                m_wen   = 1'b1;
                m_data  = slot[w];
                m_last  = w;
            end
        end
    end

    always @(negedge clk) begin
        check("gnt", 32'(gnt), 32'(m_gnt));
        check("wr_en", 32'(fifo_wr_en), 32'(m_wen));
        check("data_in", 32'(fifo_data_in), 32'(m_data));
        check("arb_state", 32'(arb_state), 32'(m_state));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        check("ack_err", 32'(ack_err), 32'(m_ackerr));
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("wr_en_eq_or_gnt", 32'(fifo_wr_en), 32'(|gnt));
    end

    // Advance to the next negedge and play the FIFO's ack for last cycle's write.
    task automatic tick();
        @(negedge clk);
        fifo_wr_ack = ack_kill ? 1'b0 : wen_prev;
        wen_prev    = fifo_wr_en;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) slot[i] = 16'hA000 + 16'(i);
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_data", 32'(fifo_data_in), 32'h0);
        check("rst_state", 32'(arb_state), 32'h0);
        check("rst_stall", 32'(stall_cnt), 32'h0);
        check("rst_err", 32'(err_cnt), 32'h0);
        check("rst_ack_err", 32'(ack_err), 32'h0);

        // 1: all requesting, rotation 0,1,2,3,0
        rst_n = 1'b1; arb_en = 1'b1; req = 4'b1111;
        tick(); check("t1_g0", 32'(gnt), 32'b0001); check("t1_d0", 32'(fifo_data_in), 32'hA000);
        tick(); check("t1_g1", 32'(gnt), 32'b0010); check("t1_d1", 32'(fifo_data_in), 32'hA001);
        tick(); check("t1_g2", 32'(gnt), 32'b0100); check("t1_d2", 32'(fifo_data_in), 32'hA002);
        tick(); check("t1_g3", 32'(gnt), 32'b1000); check("t1_d3", 32'(fifo_data_in), 32'hA003);
        tick(); check("t1_g4", 32'(gnt), 32'b0001); check("t1_wen", 32'(fifo_wr_en), 32'h1);

        // 2: full for three cycles, then rotation resumes at index 2
        req = 4'b0101; fifo_full = 1'b1;
        tick(); check("t2_state", 32'(arb_state), 32'b10); check("t2_gnt", 32'(gnt), 32'h0);
        tick();
        tick(); check("t2_stall", 32'(stall_cnt), 32'd3);
        fifo_full = 1'b0;
        tick(); check("t2_resume", 32'(gnt), 32'b0100); check("t2_state_g", 32'(arb_state), 32'b01);

        // 3: almostfull with a write in flight forces a one-cycle gap
        req = 4'b0010; fifo_almostfull = 1'b1;
        tick(); check("t3_gap", 32'(gnt), 32'h0); check("t3_stall", 32'(stall_cnt), 32'd4);
        tick(); check("t3_gnt", 32'(gnt), 32'b0010);
        fifo_almostfull = 1'b0;

        // 4: missing ack, then a clean write, then an overflowed write
        req = 4'b0000; ack_kill = 1'b1;
        tick();
        ack_kill = 1'b0;
        tick(); check("t4_err", 32'(err_cnt), 32'd1); check("t4_ack_err", 32'(ack_err), 32'h1);
        req = 4'b0001;
        tick(); check("t4_gnt", 32'(gnt), 32'b0001);
        req = 4'b0000;
        tick();
        tick(); check("t4_err_keep", 32'(err_cnt), 32'd1); check("t4_sticky", 32'(ack_err), 32'h1);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        fifo_overflow = 1'b1;
        tick(); check("t4_ovf_err", 32'(err_cnt), 32'd2);
        fifo_overflow = 1'b0;

        // 5: reset while a grant is out
        req = 4'b0100;
        tick(); check("t5_gnt", 32'(gnt), 32'b0100);
        rst_n = 1'b0; req = 4'b1111;
        tick(); check("t5_rgnt", 32'(gnt), 32'h0); check("t5_rerr", 32'(err_cnt), 32'h0);
        check("t5_rack", 32'(ack_err), 32'h0);
        rst_n = 1'b1;
        tick(); check("t5_first", 32'(gnt), 32'b0001);
        tick(); check("t5_second", 32'(gnt), 32'b0010); check("t5_noerr", 32'(err_cnt), 32'h0);

        // 6: arbitration disabled, then resumes from last+1
        arb_en = 1'b0;
        tick(); check("t6_idle", 32'(arb_state), 32'b00); check("t6_gnt", 32'(gnt), 32'h0);
        tick(); check("t6_stall", 32'(stall_cnt), 32'h0);
        arb_en = 1'b1;
        tick(); check("t6_resume", 32'(gnt), 32'b0100);

        // stall counter saturation
        fifo_full = 1'b1;
        repeat (260) tick();
        check("sat_stall", 32'(stall_cnt), 32'hFF);
        check("sat_state", 32'(arb_state), 32'b10);
        fifo_full = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that lets NUM_REQ independent producers share the single write port of the team's synchronous FIFO. It grants at most one requester per cycle and drives the registered wr_en/data_in. It throttles on full/almostfull so the FIFO never overflows. It also checks every issued write for a wr_ack one cycle later and keeps stall/error statistics.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
FIFO_WIDTH, 16, data width, equal to the FIFO data_in width
CNT_WIDTH, 8, width of the saturating statistic counters

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  reset, synchronous, active-low
arb_en  in  1  1 = arbitration enabled; 0 = no new grants
req  in  NUM_REQ  request per requester; held with data until granted
req_data  in  NUM_REQ*FIFO_WIDTH  slice i = [i*FIFO_WIDTH +: FIFO_WIDTH]
gnt  out  NUM_REQ  one-hot, registered; a pulse means that requester's word was issued this cycle
fifo_wr_en  out  1  to FIFO wr_en, registered
fifo_data_in  out  FIFO_WIDTH  to FIFO data_in, registered
fifo_full  in  1  FIFO full
fifo_almostfull  in  1  FIFO almostfull (count == DEPTH-1)
fifo_wr_ack  in  1  FIFO wr_ack (registered in FIFO, one cycle after wr_en)
fifo_overflow  in  1  FIFO overflow
arb_state  out  2  00 IDLE, 01 GRANT, 10 BLOCKED
stall_cnt  out  CNT_WIDTH  cycles spent in BLOCKED, saturating
err_cnt  out  CNT_WIDTH  issued writes that were not acked or that overflowed, saturating
ack_err  out  1  sticky; set on the first ack error

Behaviour:
- Reset: sampled on posedge when rst_n=0. All outputs go to 0. arb_state=IDLE. The internal last-grant pointer is set to NUM_REQ-1, so index 0 wins first. The in-flight flag is cleared. Reset mid-write drops the ack check for that write.
- blocked = fifo_full | (fifo_almostfull & fifo_wr_en). This reserves the last slot for the write already in flight. Reads freeing space are ignored, which is conservative.
- Each posedge with arb_en=1, at least one req, and !blocked:
  - the winner is the first set req at or after index (last+1) mod NUM_REQ, searching upward with wrap;
  - next cycle: gnt[winner]=1, fifo_wr_en=1, fifo_data_in = req_data slice captured at the decision edge;
  - last <= winner.
- Otherwise, next cycle gnt=0 and fifo_wr_en=0; fifo_data_in holds its last value.
- Single-cycle latency from req to gnt. Back-to-back grants are allowed, so a lone continuous requester gets a gnt every cycle.
- A requester seeing gnt may change req/data in the same cycle. The arbiter re-samples req at that edge, which allows consecutive grants to the same requester.
- FSM (registered classification of the same edge):
  - IDLE when arb_en=0 or no req;
  - GRANT when a grant is issued;
  - BLOCKED when arb_en=1, any req, and blocked.
  - Any state can move to any state each cycle.
- stall_cnt increments for every edge whose next state is BLOCKED and saturates at all-ones.
- Ack check: an in-flight flag is set when fifo_wr_en=1. On the following edge, if the flag is set and (fifo_wr_ack==0 or fifo_overflow==1):
  - err_cnt increments (saturating);
  - ack_err is set and stays set until reset.
- Deasserting arb_en stops new grants only. An in-flight write is still ack-checked.
- gnt is always one-hot or zero. fifo_wr_en == |gnt at all times.

Test Plan:
1. req=4'b1111 held, fifo_full=0, almostfull=0 → gnt sequence 0001, 0010, 0100, 1000, 0001; fifo_wr_en=1 every cycle; data_in tracks the matching slice.
2. req=4'b0101 held, then fifo_full=1 for 3 cycles → gnt=0 and arb_state=BLOCKED for 3 cycles, stall_cnt=3; after full drops, the grant resumes at the next index in rotation.
3. fifo_almostfull=1 while fifo_wr_en=1, req=4'b0010 → next cycle gnt=0 (one-cycle gap); the following cycle gnt=0010 provided almostfull has dropped or wr_en=0.
4. One write issued, bench drives fifo_wr_ack=0 next cycle → err_cnt=1, ack_err=1; a later correctly acked write leaves err_cnt=1 and ack_err=1.
5. rst_n=0 for one edge while gnt=0100, then req=4'b1111 → gnt=0 and all counters 0 after reset; first grant is 0001; no ack error is logged for the dropped write.
6. arb_en=0 with req=4'b1111 → arb_state=IDLE, no gnt, stall_cnt unchanged; re-enable → gnt resumes from last+1.
